// File: rtl/traffic_pkg.sv
// Shared types for the two-approach traffic phase controller: state codes, buzzer codes
// and the per-approach lamp vector.
package traffic_pkg;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StEwG  = 4'd1,
    StEwY  = 4'd2,
    StEwL  = 4'd3,
    StEwAr = 4'd4,
    StNsG  = 4'd5,
    StNsY  = 4'd6,
    StNsL  = 4'd7,
    StNsAr = 4'd8
  } state_e;

  localparam logic [1:0] RingOff  = 2'b00;
  localparam logic [1:0] RingSlow = 2'b01;
  localparam logic [1:0] RingFast = 2'b10;

  typedef struct packed {
    logic g;
    logic y;
    logic r;
    logic l;
  } lamp_t;

  localparam lamp_t LampRed = lamp_t'(4'b0010);

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter holding the cycles left in the current phase; saturates at zero.
module phase_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic [CNT_W-1:0] remain,
  output logic [CNT_W-1:0] remain_nxt,
  output logic             done
);

  localparam logic [CNT_W-1:0] One = 1;

  logic [CNT_W-1:0] r_remain;
  logic [CNT_W-1:0] w_remain_d;

  always_comb begin
    w_remain_d = r_remain;
    if (load) begin
      w_remain_d = load_val;
    end else if (!hold && (r_remain != '0)) begin
      w_remain_d = r_remain - One;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_remain <= '0;
    end else begin
      r_remain <= w_remain_d;
    end
  end

  assign remain     = r_remain;
  assign remain_nxt = w_remain_d;
  assign done       = (r_remain == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-approach intersection sequencer with optional left arrows and all-red clearance,
// programmable durations, a countdown output and a two-level buzzer code.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned WARN_G = 10,
  parameter int unsigned WARN_Y = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] g_time,
  input  logic [CNT_W-1:0] y_time,
  input  logic [CNT_W-1:0] l_time,
  input  logic [CNT_W-1:0] ar_time,
  input  logic [1:0]       left_en,
  output logic             ew_g,
  output logic             ew_y,
  output logic             ew_r,
  output logic             ew_l,
  output logic             ns_g,
  output logic             ns_y,
  output logic             ns_r,
  output logic             ns_l,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] remain,
  output logic [1:0]       ring
);

  localparam logic [CNT_W-1:0] One   = 1;
  localparam logic [CNT_W-1:0] WarnG = CNT_W'(WARN_G);
  localparam logic [CNT_W-1:0] WarnY = CNT_W'(WARN_Y);

  state_e           r_state;
  state_e           w_state_nxt;
  state_e           w_succ;
  logic             r_pause;
  logic [1:0]       r_ring;
  logic [1:0]       w_ring_nxt;
  logic [CNT_W-1:0] w_dur;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_remain_nxt;
  logic             w_load;
  logic             w_done;
  logic             w_run;
  logic             w_ew_l_ok;
  logic             w_ns_l_ok;
  logic             w_ar_ok;
  lamp_t            w_ew;
  lamp_t            w_ns;

  assign w_run     = start & ~stop;
  assign w_ew_l_ok = left_en[1] & (l_time != '0);
  assign w_ns_l_ok = left_en[0] & (l_time != '0);
  assign w_ar_ok   = (ar_time != '0);

  // Successor with all skips resolved, so a chain of skipped phases costs no extra edge.
  always_comb begin
    w_succ = StIdle;
    unique case (r_state)
      StIdle:  w_succ = StEwG;
      StEwG:   w_succ = StEwY;
      StEwY:   w_succ = w_ew_l_ok ? StEwL : (w_ar_ok ? StEwAr : StNsG);
      StEwL:   w_succ = w_ar_ok ? StEwAr : StNsG;
      StEwAr:  w_succ = StNsG;
      StNsG:   w_succ = StNsY;
      StNsY:   w_succ = w_ns_l_ok ? StNsL : (w_ar_ok ? StNsAr : StEwG);
      StNsL:   w_succ = w_ar_ok ? StNsAr : StEwG;
      StNsAr:  w_succ = StEwG;
      default: w_succ = StIdle;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!start) begin
      w_state_nxt = StIdle;
    end else if (!stop && ((r_state == StIdle) || w_done)) begin
      w_state_nxt = w_succ;
    end
  end

  always_comb begin
    w_dur = '0;
    unique case (w_state_nxt)
      StEwG, StNsG:   w_dur = g_time;
      StEwY, StNsY:   w_dur = y_time;
      StEwL, StNsL:   w_dur = l_time;
      StEwAr, StNsAr: w_dur = ar_time;
      default:        w_dur = '0;
    endcase
  end

  // A zero duration still occupies one cycle.
  assign w_load_val = (w_dur == '0) ? '0 : (w_dur - One);
  assign w_load     = (w_state_nxt != r_state);

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .load_val  (w_load_val),
    .hold      (~w_run),
    .remain    (remain),
    .remain_nxt(w_remain_nxt),
    .done      (w_done)
  );

  always_comb begin
    w_ring_nxt = RingOff;
    if (w_run) begin
      if (((w_state_nxt == StEwG) || (w_state_nxt == StNsG)) && (w_remain_nxt < WarnG)) begin
        w_ring_nxt = RingSlow;
      end else if (((w_state_nxt == StEwY) || (w_state_nxt == StNsY)) &&
                   (w_remain_nxt < WarnY)) begin
        w_ring_nxt = RingFast;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_pause <= 1'b0;
      r_ring  <= RingOff;
    end else begin
      r_state <= w_state_nxt;
      r_pause <= start & stop;
      r_ring  <= w_ring_nxt;
    end
  end

  always_comb begin
    w_ew = LampRed;
    w_ns = LampRed;
    if (!r_pause) begin
      unique case (r_state)
        StEwG:   w_ew = lamp_t'(4'b1000);
        StEwY:   w_ew = lamp_t'(4'b0100);
        StEwL:   w_ew.l = 1'b1;
        StNsG:   w_ns = lamp_t'(4'b1000);
        StNsY:   w_ns = lamp_t'(4'b0100);
        StNsL:   w_ns.l = 1'b1;
        default: begin
          w_ew = LampRed;
          w_ns = LampRed;
        end
      endcase
    end
  end

  assign {ew_g, ew_y, ew_r, ew_l} = w_ew;
  assign {ns_g, ns_y, ns_r, ns_l} = w_ns;
  assign state = r_state;
  assign ring  = r_ring;

endmodule
